// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus of imem_fetch_ctrl: pipeline control, instruction memory port and IF/ID outputs.
// master is the fetch controller; slave is the memory/pipeline side.
interface imem_fetch_ctrl_if;
  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] address;
  logic [31:0] instruction;
  logic [31:0] if_instruction;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    input  start, stall, redirect, redirect_target, instruction,
    output address, if_instruction, if_pc4, if_valid, halted, fault, fetch_count
  );

  modport slave (
    output start, stall, redirect, redirect_target, instruction,
    input  address, if_instruction, if_pc4, if_valid, halted, fault, fetch_count
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers fetched words into IF/ID, stops on HALT_WORD.
// Optional PC range checking against IMEM_BYTES is enabled by defining PC_BOUND_CHECK_EN.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  imem_fetch_ctrl_if.master bus
);

`ifdef PC_BOUND_CHECK_EN
  localparam logic BOUND_CHECK = 1'b1;
`else
  localparam logic BOUND_CHECK = 1'b0;
`endif

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] if_instr_r, if_instr_s;
  logic [31:0] if_pc4_r, if_pc4_s;
  logic        if_valid_r, if_valid_s;
  logic        halted_r, halted_s;
  logic        fault_r, fault_s;
  logic [31:0] count_r, count_s;

  logic [32:0] pc_plus4_s;
  logic [31:0] target_s;
  logic        step_fault_s;
  logic        redir_fault_s;

  // 33-bit sum so the bound compare sees a carry out of the top instead of a wrapped PC
  assign pc_plus4_s    = {1'b0, pc_r} + 33'd4;
  assign target_s      = {bus.redirect_target[31:2], 2'b00};
  assign step_fault_s  = BOUND_CHECK && (pc_plus4_s >= IMEM_LIMIT);
  assign redir_fault_s = BOUND_CHECK && ({1'b0, target_s} >= IMEM_LIMIT);

  // State register and all IF/ID, PC and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      if_instr_r <= 32'h0000_0000;
      if_pc4_r   <= 32'h0000_0000;
      if_valid_r <= 1'b0;
      halted_r   <= 1'b0;
      fault_r    <= 1'b0;
      count_r    <= 32'h0000_0000;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      if_instr_r <= if_instr_s;
      if_pc4_r   <= if_pc4_s;
      if_valid_r <= if_valid_s;
      halted_r   <= halted_s;
      fault_r    <= fault_s;
      count_r    <= count_s;
    end
  end

  // Next-state and next-register logic; priority in FETCH is redirect > stall > halt > step
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    if_instr_s = if_instr_r;
    if_pc4_s   = if_pc4_r;
    if_valid_s = if_valid_r;
    halted_s   = halted_r;
    fault_s    = fault_r;
    count_s    = count_r;
    case (state_r)
      IDLE: begin
        if_valid_s = 1'b0;
        if (bus.start) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (bus.redirect) begin
          if (redir_fault_s) begin
            fault_s    = 1'b1;
            halted_s   = 1'b1;
            if_valid_s = 1'b0;
            state_s    = HALT;
          end else begin
            pc_s       = target_s;
            if_valid_s = 1'b0;
            if_instr_s = 32'h0000_0000;
          end
        end else if (bus.stall) begin
          state_s = FETCH;
        end else if (bus.instruction == HALT_WORD) begin
          if_valid_s = 1'b0;
          halted_s   = 1'b1;
          state_s    = HALT;
        end else if (step_fault_s) begin
          fault_s    = 1'b1;
          halted_s   = 1'b1;
          if_valid_s = 1'b0;
          state_s    = HALT;
        end else begin
          if_instr_s = bus.instruction;
          if_pc4_s   = pc_plus4_s[31:0];
          if_valid_s = 1'b1;
          pc_s       = pc_plus4_s[31:0];
          count_s    = count_r + 32'd1;
        end
      end
      HALT: begin
        if_valid_s = 1'b0;
        // A latched fault locks the sequencer in HALT until reset
        if (bus.redirect && !fault_r) begin
          if (redir_fault_s) begin
            fault_s = 1'b1;
          end else begin
            pc_s     = target_s;
            halted_s = 1'b0;
            state_s  = FETCH;
          end
        end else begin
          state_s = HALT;
        end
      end
      default: begin
        state_s    = IDLE;
        if_valid_s = 1'b0;
      end
    endcase
  end

  assign bus.address        = pc_r;
  assign bus.if_instruction = if_instr_r;
  assign bus.if_pc4         = if_pc4_r;
  assign bus.if_valid       = if_valid_r;
  assign bus.halted         = halted_r;
  assign bus.fault          = fault_r;
  assign bus.fetch_count    = count_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a four-word program memory model.
// The DUT uses IMEM_BYTES=16 so the bound-check build exercises the fault path.
module tb_imem_fetch_ctrl;
  logic clk;
  logic reset;
  int   checks_total;
  int   checks_passed;

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hFFFF_FFFF),
    .IMEM_BYTES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: imem = 32'h2008_0001;
      32'h0000_0004: imem = 32'h2009_0002;
      32'h0000_0008: imem = 32'h0109_5020;
      32'h0000_000C: imem = 32'hFFFF_FFFF;
      default:       imem = 32'h0000_0000;
    endcase
  endfunction

  always_comb bus.instruction = imem(bus.address);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'h0000_0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_fetch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks_total++; if (bus.address !== 32'h0) $display("FAIL reset_address got=%h exp=%h", bus.address, 32'h0); else checks_passed++;
    checks_total++; if (bus.if_instruction !== 32'h0) $display("FAIL reset_if_instr got=%h exp=%h", bus.if_instruction, 32'h0); else checks_passed++;
    checks_total++; if (bus.if_pc4 !== 32'h0) $display("FAIL reset_if_pc4 got=%h exp=%h", bus.if_pc4, 32'h0); else checks_passed++;
    checks_total++; if ({bus.if_valid, bus.halted, bus.fault} !== 3'b000) $display("FAIL reset_flags got=%b exp=%b", {bus.if_valid, bus.halted, bus.fault}, 3'b000); else checks_passed++;
    checks_total++; if (bus.fetch_count !== 32'h0) $display("FAIL reset_count got=%0d exp=%0d", bus.fetch_count, 0); else checks_passed++;
    // IDLE ignores redirect and stall
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h0000_0008;
    bus.stall = 1'b1;
    tick();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    tick();
    checks_total++; if (bus.address !== 32'h0) $display("FAIL idle_ignore_addr got=%h exp=%h", bus.address, 32'h0); else checks_passed++;
    checks_total++; if (bus.if_valid !== 1'b0) $display("FAIL idle_valid got=%b exp=%b", bus.if_valid, 1'b0); else checks_passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_instr [3];
    logic [31:0] exp_pc4 [3];
    exp_instr = '{32'h2008_0001, 32'h2009_0002, 32'h0109_5020};
    exp_pc4   = '{32'h4, 32'h8, 32'hC};
    do_reset();
    start_fetch();
    checks_total++; if (bus.if_valid !== 1'b0 || bus.address !== 32'h0) $display("FAIL b2b_first valid=%b addr=%h exp valid=0 addr=0", bus.if_valid, bus.address); else checks_passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks_total++; if (bus.if_instruction !== exp_instr[i]) $display("FAIL b2b_instr%0d got=%h exp=%h", i, bus.if_instruction, exp_instr[i]); else checks_passed++;
      checks_total++; if (bus.if_pc4 !== exp_pc4[i]) $display("FAIL b2b_pc4_%0d got=%h exp=%h", i, bus.if_pc4, exp_pc4[i]); else checks_passed++;
      checks_total++; if (bus.if_valid !== 1'b1) $display("FAIL b2b_valid%0d got=%b exp=%b", i, bus.if_valid, 1'b1); else checks_passed++;
    end
    tick();
    checks_total++; if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0) $display("FAIL b2b_halt halted=%b valid=%b exp 1/0", bus.halted, bus.if_valid); else checks_passed++;
    checks_total++; if (bus.fetch_count !== 32'd3) $display("FAIL b2b_count got=%0d exp=%0d", bus.fetch_count, 3); else checks_passed++;
    checks_total++; if (bus.address !== 32'hC) $display("FAIL b2b_halt_addr got=%h exp=%h", bus.address, 32'hC); else checks_passed++;
  endtask

  task automatic test_stall();
    do_reset();
    start_fetch();
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks_total++; if (bus.if_instruction !== 32'h2008_0001) $display("FAIL stall_instr%0d got=%h exp=%h", i, bus.if_instruction, 32'h2008_0001); else checks_passed++;
      checks_total++; if (bus.address !== 32'h4) $display("FAIL stall_addr%0d got=%h exp=%h", i, bus.address, 32'h4); else checks_passed++;
      checks_total++; if (bus.fetch_count !== 32'd1) $display("FAIL stall_count%0d got=%0d exp=%0d", i, bus.fetch_count, 1); else checks_passed++;
    end
    bus.stall = 1'b0;
    tick();
    checks_total++; if (bus.if_instruction !== 32'h2009_0002 || bus.if_pc4 !== 32'h8) $display("FAIL stall_resume instr=%h pc4=%h exp 20090002/8", bus.if_instruction, bus.if_pc4); else checks_passed++;
    checks_total++; if (bus.fetch_count !== 32'd2) $display("FAIL stall_resume_count got=%0d exp=%0d", bus.fetch_count, 2); else checks_passed++;
  endtask

  task automatic test_redirect();
    do_reset();
    start_fetch();
    tick();
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h0000_0009;
    bus.stall = 1'b1;
    tick();
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    checks_total++; if (bus.address !== 32'h8) $display("FAIL redir_addr got=%h exp=%h", bus.address, 32'h8); else checks_passed++;
    checks_total++; if (bus.if_valid !== 1'b0 || bus.if_instruction !== 32'h0) $display("FAIL redir_flush valid=%b instr=%h exp 0/0", bus.if_valid, bus.if_instruction); else checks_passed++;
    tick();
    checks_total++; if (bus.if_instruction !== 32'h0109_5020 || bus.if_pc4 !== 32'hC) $display("FAIL redir_next instr=%h pc4=%h exp 01095020/c", bus.if_instruction, bus.if_pc4); else checks_passed++;
    checks_total++; if (bus.fetch_count !== 32'd2) $display("FAIL redir_count got=%0d exp=%0d", bus.fetch_count, 2); else checks_passed++;
  endtask

  task automatic test_halt_restart();
    do_reset();
    start_fetch();
    for (int i = 0; i < 4; i++) tick();
    bus.start = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    checks_total++; if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0) $display("FAIL halt_hold halted=%b valid=%b exp 1/0", bus.halted, bus.if_valid); else checks_passed++;
    checks_total++; if (bus.address !== 32'hC) $display("FAIL halt_hold_addr got=%h exp=%h", bus.address, 32'hC); else checks_passed++;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h0;
    tick();
    bus.redirect = 1'b0;
    checks_total++; if (bus.halted !== 1'b0 || bus.address !== 32'h0) $display("FAIL halt_redir halted=%b addr=%h exp 0/0", bus.halted, bus.address); else checks_passed++;
    tick();
    checks_total++; if (bus.if_instruction !== 32'h2008_0001 || bus.if_valid !== 1'b1) $display("FAIL halt_restart instr=%h valid=%b exp 20080001/1", bus.if_instruction, bus.if_valid); else checks_passed++;
    checks_total++; if (bus.fetch_count !== 32'd4) $display("FAIL halt_restart_count got=%0d exp=%0d", bus.fetch_count, 4); else checks_passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    start_fetch();
    tick();
    tick();
    checks_total++; if (bus.address !== 32'h8) $display("FAIL midrst_pre_addr got=%h exp=%h", bus.address, 32'h8); else checks_passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks_total++; if (bus.address !== 32'h0 || bus.if_valid !== 1'b0) $display("FAIL midrst_state addr=%h valid=%b exp 0/0", bus.address, bus.if_valid); else checks_passed++;
    checks_total++; if (bus.fetch_count !== 32'd0 || bus.if_instruction !== 32'h0) $display("FAIL midrst_regs count=%0d instr=%h exp 0/0", bus.fetch_count, bus.if_instruction); else checks_passed++;
    tick();
    checks_total++; if (bus.address !== 32'h0 || bus.if_valid !== 1'b0) $display("FAIL midrst_idle addr=%h valid=%b exp 0/0", bus.address, bus.if_valid); else checks_passed++;
  endtask

  task automatic test_bound();
    do_reset();
    start_fetch();
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h0000_0010;
    tick();
    bus.redirect = 1'b0;
`ifdef PC_BOUND_CHECK_EN
    checks_total++; if ({bus.fault, bus.halted, bus.if_valid} !== 3'b110) $display("FAIL bound_fault got=%b exp=%b", {bus.fault, bus.halted, bus.if_valid}, 3'b110); else checks_passed++;
    checks_total++; if (bus.address !== 32'h0) $display("FAIL bound_pc_hold got=%h exp=%h", bus.address, 32'h0); else checks_passed++;
    bus.redirect = 1'b1;
    bus.redirect_target = 32'h0;
    tick();
    bus.redirect = 1'b0;
    tick();
    checks_total++; if ({bus.fault, bus.halted, bus.if_valid} !== 3'b110) $display("FAIL bound_sticky got=%b exp=%b", {bus.fault, bus.halted, bus.if_valid}, 3'b110); else checks_passed++;
    do_reset();
    checks_total++; if (bus.fault !== 1'b0) $display("FAIL bound_reset got=%b exp=%b", bus.fault, 1'b0); else checks_passed++;
`else
    checks_total++; if ({bus.fault, bus.halted, bus.if_valid} !== 3'b000) $display("FAIL nobound_flags got=%b exp=%b", {bus.fault, bus.halted, bus.if_valid}, 3'b000); else checks_passed++;
    checks_total++; if (bus.address !== 32'h10) $display("FAIL nobound_addr got=%h exp=%h", bus.address, 32'h10); else checks_passed++;
    tick();
    checks_total++; if (bus.if_valid !== 1'b1 || bus.if_pc4 !== 32'h14) $display("FAIL nobound_fetch valid=%b pc4=%h exp 1/14", bus.if_valid, bus.if_pc4); else checks_passed++;
    // PC+4 wraps from the top of the address space
    bus.redirect = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFF;
    tick();
    bus.redirect = 1'b0;
    checks_total++; if (bus.address !== 32'hFFFF_FFFC) $display("FAIL wrap_target got=%h exp=%h", bus.address, 32'hFFFF_FFFC); else checks_passed++;
    tick();
    checks_total++; if (bus.address !== 32'h0 || bus.if_pc4 !== 32'h0 || bus.if_valid !== 1'b1) $display("FAIL wrap_pc addr=%h pc4=%h valid=%b exp 0/0/1", bus.address, bus.if_pc4, bus.if_valid); else checks_passed++;
`endif
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_target = 32'h0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_halt_restart();
    test_mid_reset();
    test_bound();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
